// File: rtl/candy_regfile_mp.sv
// candy_regfile_mp: 2W/NR register file, post-reset clearing, zero reg, optional same-cycle bypass (CANDY_REGS_BYPASS_EN)
module candy_regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     ready
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic ready_q, ready_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  always_comb begin
    state_d = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_d = mem_q;
    if (state_q == CLEAR) begin
      mem_d[clr_cnt_q] = '0;
      clr_cnt_d = clr_cnt_q + 1'b1;
      state_d = (clr_cnt_q == '1) ? RUN : CLEAR;
    end else begin
      if (we0 && waddr0 != '0) mem_d[waddr0] = wdata0;
      if (we1 && waddr1 != '0) mem_d[waddr1] = wdata1;
    end
    ready_d = (state_d == RUN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_cnt_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q <= ready_d;
      mem_q <= mem_d;
    end
  end
  assign ready = ready_q;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    assign a = raddr[k*ADDR_W +: ADDR_W];
`ifdef CANDY_REGS_BYPASS_EN
    assign v = (we1 && waddr1 == a) ? wdata1 : (we0 && waddr0 == a) ? wdata0 : mem_q[a];
`else
    assign v = mem_q[a];
`endif
    assign rdata[k*DATA_W +: DATA_W] = (re[k] && ready_q && !rst && a != '0) ? v : '0;
  end
endmodule
